count_sequencer: RTL

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_sequencer_if.sv | 26 ++
 rtl/count_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/count_sequencer_if.sv
// rtl/count_sequencer_if.sv - control/status bundle between count_sequencer and its external 4-bit counter
interface count_sequencer_if;
  logic       start;
  logic       stop;
  logic [3:0] start_val;
  logic [3:0] end_val;
  logic       bounce;
  logic [3:0] count_fb;
  logic       load;
  logic [3:0] load_val;
  logic       count_en;
  logic       up;
  logic       busy;
  logic       done;
  logic       turn;

  modport master (
    output start, stop, start_val, end_val, bounce, count_fb,
    input  load, load_val, count_en, up, busy, done, turn
  );

  modport slave (
    input  start, stop, start_val, end_val, bounce, count_fb,
    output load, load_val, count_en, up, busy, done, turn
  );
endinterface

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - steps an external 4-bit counter from start_val to end_val, one step per DIV clocks
// Ping-pong between the two values is compiled in with BOUNCE_EN.
module count_sequencer #(
  parameter int unsigned DIV = 25_000_000
) (
  input logic              clk_50MHz,
  input logic              reset,
  count_sequencer_if.slave sif
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [25:0] PSC_LAST = 26'(DIV - 1);

  state_t      state, state_nxt;
  logic [3:0]  start_r, end_r, target, target_nxt;
  logic [25:0] psc, psc_nxt;
  logic        dir, dir_nxt;
  logic        capture, turn_nxt, count_en_nxt, bouncing;

`ifdef BOUNCE_EN
  logic bnc_r;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      bnc_r <= 1'b0;
    end else if (capture) begin
      bnc_r <= sif.bounce;
    end
  end

  // equal endpoints have nothing to bounce between, so such runs still finish
  assign bouncing = bnc_r && (start_r != end_r);
`else
  logic unused_bounce;
  assign unused_bounce = sif.bounce;
  assign bouncing      = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    psc_nxt    = psc;
    target_nxt = target;
    dir_nxt    = dir;
    turn_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (sif.start && !sif.stop) begin
          state_nxt = LOAD;
          capture   = 1'b1;
        end
      end
      LOAD: begin
        if (sif.stop) begin
          state_nxt = IDLE;
        end else begin
          state_nxt  = RUN;
          target_nxt = end_r;
          dir_nxt    = (end_r >= start_r);
        end
      end
      RUN: begin
        if (sif.stop) begin
          state_nxt = IDLE;
        end else begin
          psc_nxt = (psc == PSC_LAST) ? 26'd0 : psc + 26'd1;
          if (sif.count_fb == target) begin
            if (bouncing) begin
              target_nxt = (target == end_r) ? start_r : end_r;
              dir_nxt    = !dir;
              turn_nxt   = 1'b1;
            end else begin
              state_nxt = DONE;
            end
          end
        end
      end
      DONE: begin
        if (sif.stop) begin
          state_nxt = IDLE;
        end else if (sif.start) begin
          state_nxt = LOAD;
          capture   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // direction is needed on up already during the LOAD cycle
    if (capture) begin
      target_nxt = sif.end_val;
      dir_nxt    = (sif.end_val >= sif.start_val);
    end
    if (state_nxt != RUN) psc_nxt = 26'd0;
    if (state_nxt == IDLE) dir_nxt = 1'b0;

    // strobe is registered, so decide it one cycle early against next-cycle target
    count_en_nxt = (state_nxt == RUN) && (psc_nxt == PSC_LAST) && (sif.count_fb != target_nxt);
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      start_r      <= 4'd0;
      end_r        <= 4'd0;
      target       <= 4'd0;
      psc          <= 26'd0;
      dir          <= 1'b0;
      sif.load     <= 1'b0;
      sif.load_val <= 4'd0;
      sif.count_en <= 1'b0;
      sif.busy     <= 1'b0;
      sif.done     <= 1'b0;
      sif.turn     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        start_r <= sif.start_val;
        end_r   <= sif.end_val;
      end
      target       <= target_nxt;
      psc          <= psc_nxt;
      dir          <= dir_nxt;
      sif.load     <= capture;
      sif.load_val <= capture ? sif.start_val : 4'd0;
      sif.count_en <= count_en_nxt;
      sif.busy     <= (state_nxt == LOAD) || (state_nxt == RUN);
      sif.done     <= (state_nxt == DONE);
      sif.turn     <= turn_nxt;
    end
  end

  assign sif.up = dir;
endmodule
